// File: rtl/segment_decoder_if.sv
// -----------------------------------------------------------------------------
// segment_decoder_if
// Bundles the scan request, the segment image and the scan results of
// segment_decoder.
//
// Handshake: `start` is a single-cycle request with no ready. It is taken
// only while the decoder is idle (busy == 0, state_dbg == IDLE); a request
// made while busy is dropped, not queued. Each accepted request produces
// exactly one `done` pulse unless reset intervenes. `result` and `error`
// are valid from the `done` cycle and hold until the next `done`.
//
// Signals
//   start      master->slave  scan request
//   segments   master->slave  64-bit display image, display i at [8i+7:8i]
//   busy       slave->master  scan in progress (SCAN and DONE states)
//   done       slave->master  one-cycle completion pulse
//   result     slave->master  decoded digits, nibble i = display i
//   error      slave->master  last scan held an unrecognised pattern
//   state_dbg  slave->master  current FSM state (0 IDLE, 1 SCAN, 2 DONE)
// -----------------------------------------------------------------------------
interface segment_decoder_if;
  logic        start;
  logic [63:0] segments;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        error;
  logic [1:0]  state_dbg;

  modport master (
    output start, segments,
    input  busy, done, result, error, state_dbg
  );

  modport slave (
    input  start, segments,
    output busy, done, result, error, state_dbg
  );
endinterface

// File: rtl/segment_decoder.sv
// -----------------------------------------------------------------------------
// segment_decoder
// Decodes the eight-display seven-segment image back into eight 4-bit digit
// codes. A scan snapshots the image on accept, decodes one display per cycle
// into a shadow register, and publishes result/error on entry to DONE so the
// output never shows a partially decoded scan.
//
// Digit codes: 0-9 for digits, 0xA for minus, 0xF for blank, 0xE for an
// unrecognised pattern (which also raises `error`). The dp bit is ignored.
//
// Ports
//   clock  rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    segment_decoder_if.slave (start, segments, busy, done, result,
//          error, state_dbg)
//
// Optional feature: define SEG_DECODER_AUTO_EN to start a scan automatically
// whenever the image differs from the last accepted snapshot while idle.
// -----------------------------------------------------------------------------
module segment_decoder (
  input  logic               clock,
  input  logic               reset,
  segment_decoder_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  index_q;
  logic [63:0] snap_q;
  logic [31:0] shadow_q;
  logic [31:0] result_q;
  logic        err_acc_q;
  logic        error_q;

  logic        trigger;
  logic        accept;
  logic [6:0]  cur_pat;
  logic [3:0]  digit;
  logic        digit_bad;

  // Returns {bad, code}. Only segments g..a are examined.
  function automatic logic [4:0] decode(input logic [6:0] pat);
    logic [4:0] r;
    case (pat)
      7'h3F:   r = 5'h00;
      7'h06:   r = 5'h01;
      7'h5B:   r = 5'h02;
      7'h4F:   r = 5'h03;
      7'h66:   r = 5'h04;
      7'h6D:   r = 5'h05;
      7'h7D:   r = 5'h06;
      7'h07:   r = 5'h07;
      7'h7F:   r = 5'h08;
      7'h6F:   r = 5'h09;
      7'h40:   r = 5'h0A;
      7'h00:   r = 5'h0F;
      default: r = 5'h1E;
    endcase
    return r;
  endfunction

  // The snapshot doubles as the copy of the last accepted image, so the
  // auto-trigger compare needs no extra storage.
`ifdef SEG_DECODER_AUTO_EN
  assign trigger = bus.start | (bus.segments != snap_q);
`else
  assign trigger = bus.start;
`endif

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    cur_pat = snap_q[{index_q, 3'b000} +: 7];
    {digit_bad, digit} = decode(cur_pat);
    case (state_q)
      IDLE: begin
        if (trigger) begin
          accept  = 1'b1;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (index_q == 3'd7) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      index_q   <= 3'd0;
      snap_q    <= 64'd0;
      shadow_q  <= 32'd0;
      result_q  <= 32'd0;
      err_acc_q <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        snap_q    <= bus.segments;
        index_q   <= 3'd0;
        err_acc_q <= 1'b0;
      end else if (state_q == SCAN) begin
        shadow_q[{index_q, 2'b00} +: 4] <= digit;
        err_acc_q <= err_acc_q | digit_bad;
        index_q   <= index_q + 3'd1;
        // Last display: publish directly, folding in the digit being
        // written to the shadow on this same edge.
        if (index_q == 3'd7) begin
          result_q <= {digit, shadow_q[27:0]};
          error_q  <= err_acc_q | digit_bad;
        end
      end
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.error     = error_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_segment_decoder.sv
// -----------------------------------------------------------------------------
// tb_segment_decoder
// Directed bench for segment_decoder (default build, auto-trigger disabled).
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_segment_decoder;

  logic clock = 1'b0;
  logic reset = 1'b0;

  segment_decoder_if bus ();

  segment_decoder dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int          tests = 0;
  int          fails = 0;
  logic [32:0] exp_q[$];        // {error, result}
  logic [31:0] last_res = 32'd0;
  logic        last_err = 1'b0;

  localparam logic [63:0] IMG_DIGITS = 64'h077D_6D66_4F5B_063F;
  localparam logic [63:0] IMG_MINUS  = 64'h4000_0000_0000_0086;
  localparam logic [63:0] IMG_BAD3   = 64'h3F3F_3F3F_553F_3F3F;
  localparam logic [63:0] IMG_ZEROS  = 64'h3F3F_3F3F_3F3F_3F3F;
  localparam logic [63:0] IMG_89     = 64'h7FEF_7F6F_FF6F_7F6F;
  localparam logic [63:0] IMG_MIXED  = 64'h8001_4006_0000_5B80;
  localparam logic [63:0] IMG_JUNK   = 64'h5555_5555_5555_5555;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called on a falling edge; returns on the falling edge after accept edge k.
  task automatic pulse_start(input logic [63:0] segs);
    bus.segments = segs;
    bus.start    = 1'b1;
    @(negedge clock);
    bus.start    = 1'b0;
  endtask

  // n is the number of falling edges seen since accept edge k.
  task automatic wait_done(input string tag, input int n_start);
    int          n;
    logic [32:0] e;
    n = n_start;
    check({tag, "_busy"}, bus.busy, 1'b1);
    while (bus.done !== 1'b1 && n < 20) begin
      check({tag, "_result_hold"}, bus.result, last_res);
      check({tag, "_error_hold"}, bus.error, last_err);
      @(negedge clock);
      n++;
    end
    check({tag, "_latency"}, n, 9);
    check({tag, "_sb_depth"}, exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (bus.done === 1'b1) begin
        check({tag, "_result"}, bus.result, e[31:0]);
        check({tag, "_error"}, bus.error, e[32]);
      end
      last_res = e[31:0];
      last_err = e[32];
    end
    @(negedge clock);
    check({tag, "_done_width"}, bus.done, 1'b0);
    check({tag, "_busy_after"}, bus.busy, 1'b0);
  endtask

  task automatic quiet(input int cycles, input string tag);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      check({tag, "_done"}, bus.done, 1'b0);
      check({tag, "_busy"}, bus.busy, 1'b0);
      check({tag, "_result"}, bus.result, last_res);
      check({tag, "_error"}, bus.error, last_err);
    end
  endtask

  task automatic scan(input string tag, input logic [63:0] segs, input logic [31:0] res, input logic err);
    exp_q.push_back({err, res});
    pulse_start(segs);
    wait_done(tag, 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus.start    = 1'b0;
    bus.segments = 64'd0;

    // Reset held, then released with start low.
    repeat (3) @(negedge clock);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_result", bus.result, 32'd0);
    check("rst_error", bus.error, 1'b0);
    reset = 1'b1;
    quiet(20, "idle");

    // Basic decodes.
    scan("digits", IMG_DIGITS, 32'h7654_3210, 1'b0);
    scan("minus_blank", IMG_MINUS, 32'hAFFF_FFF1, 1'b0);
    scan("bad3", IMG_BAD3, 32'h0000_E000, 1'b1);
    scan("zeros", IMG_ZEROS, 32'h0000_0000, 1'b0);
    scan("eights_nines", IMG_89, 32'h8989_8989, 1'b0);
    // dp-only blank -> F, 0x01 -> E, minus, 1, blanks, 2, dp-only blank.
    scan("mixed", IMG_MIXED, 32'hFEA1_FF2F, 1'b1);
    quiet(3, "gap");

    // Image change at k+3 and start at k+4 do not affect the running scan.
    exp_q.push_back({1'b0, 32'h7654_3210});
    pulse_start(IMG_DIGITS);
    @(negedge clock);            // n = 2
    @(negedge clock);            // n = 3
    bus.segments = IMG_JUNK;
    @(negedge clock);            // n = 4
    bus.start = 1'b1;
    @(negedge clock);            // n = 5
    bus.start = 1'b0;
    wait_done("snapshot", 5);
    quiet(12, "no_queue");

    // Reset at k+5 aborts the scan: no done, result back to 0.
    pulse_start(IMG_DIGITS);
    repeat (4) @(negedge clock); // n = 5
    reset = 1'b0;
    #1;
    check("abort_busy", bus.busy, 1'b0);
    check("abort_done", bus.done, 1'b0);
    check("abort_result", bus.result, 32'd0);
    check("abort_error", bus.error, 1'b0);
    check("abort_state", bus.state_dbg, 2'd0);
    @(negedge clock);
    reset = 1'b1;
    last_res = 32'd0;
    last_err = 1'b0;
    quiet(15, "after_abort");

    // start held high: one scan every 10 cycles.
    bus.segments = IMG_BAD3;
    exp_q.push_back({1'b1, 32'h0000_E000});
    exp_q.push_back({1'b1, 32'h0000_E000});
    exp_q.push_back({1'b0, 32'h7654_3210});
    bus.start = 1'b1;
    for (int n = 1; n <= 29; n++) begin
      logic [32:0] e;
      @(negedge clock);
      if (n == 12) bus.segments = IMG_DIGITS;   // sampled by the third accept at k+20
      if (n % 10 == 9) begin
        check("held_done", bus.done, 1'b1);
        check("held_sb_depth", (exp_q.size() > 0), 1'b1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("held_result", bus.result, e[31:0]);
          check("held_error", bus.error, e[32]);
          last_res = e[31:0];
          last_err = e[32];
        end
      end else begin
        check("held_no_done", bus.done, 1'b0);
        check("held_busy", bus.busy, (n % 10 != 0));
      end
    end
    bus.start = 1'b0;
    quiet(5, "held_end");

    check("sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/segment_decoder.md
# segment_decoder

Reads back the 64-bit, eight-display seven-segment image produced by the display controller and decodes it into eight 4-bit digit codes packed into a 32-bit word. It drives the calculator top-level `result` output and is the decode side of the digit-to-segment encoding. A scan is started by a one-cycle request. The segment image is snapshotted on accept, then decoded one display per cycle, and completion is reported with a done pulse and a sticky error flag.

## Interface
- No parameters; display count fixed at 8, segment field fixed at 8 bits.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  scan request; accepted only in IDLE.
- `segments`  in  64  display image; display i occupies bits [8i+7:8i]; bit 7 = dp, bits 6..0 = g,f,e,d,c,b,a; 1 = lit.
- `busy`  out  1  high from the cycle after accept through the DONE cycle.
- `done`  out  1  one-cycle pulse; `result` and `error` are valid from this cycle.
- `result`  out  32  decoded digits; nibble [4i+3:4i] = display i.
- `error`  out  1  at least one display in the last scan held an unrecognised pattern.

## Operation
- FSM states:
  - IDLE: `start`=1 → SCAN, index←0, snapshot←`segments`.
  - SCAN: decode snapshot display[index]; index←index+1; after index 7 → DONE.
  - DONE: `done`=1 → IDLE.
- Decode uses bits 6..0 only; dp is ignored.
  - 0x3F→0, 0x06→1, 0x5B→2, 0x4F→3, 0x66→4, 0x6D→5, 0x7D→6, 0x07→7, 0x7F→8, 0x6F→9.
  - 0x40 (minus) → 0xA.
  - 0x00 (blank) → 0xF.
  - Any other pattern → 0xE and sets the error accumulator.
- Digits accumulate in a shadow register. `result` is loaded from the shadow on entry to DONE, so `result` never shows a partial scan.
- Error accumulator clears on accept. `error` is loaded together with `result` and holds until the next DONE.
- Changes on `segments` after accept have no effect on the scan in progress.
- `start` in SCAN or DONE is ignored, not queued.
- Reset values: state IDLE, index 0, `busy` 0, `done` 0, `result` 0x0000_0000, `error` 0, snapshot and shadow 0.

## Timing
- `start` sampled high at edge k:
  - edges k+1..k+8 decode displays 0..7;
  - state is DONE after edge k+8; `done`, `result` and `error` are valid in cycle k+9.
- A new `start` can be accepted in the IDLE cycle after DONE. Minimum start-to-start spacing is 10 cycles.
- `busy` is registered: high after edge k, low after the edge that leaves DONE.
- `done` is exactly one cycle wide.
- Asserting `reset` mid-scan forces the reset values immediately (asynchronous). No `done` is produced. `result` reads 0 until a complete scan finishes.
- `start` held high continuously: re-accepted on every IDLE cycle, giving a 10-cycle scan period.

## Configuration
- `SEG_DECODER_AUTO_EN` defined:
  - the block keeps a copy of the last accepted snapshot;
  - in IDLE, if `segments` differs from that copy, a scan is triggered exactly as if `start`=1;
  - an explicit `start` still works;
  - the copy resets to 0, so a nonzero image after reset triggers a scan automatically.
- Not defined: scans occur only on `start`; no copy register is built.

## Test plan
- Reset then idle: `reset` low then high with `start`=0 → `busy`=0, `done`=0, `result`=0x0000_0000, `error`=0 for 20 cycles.
- Display i holds the pattern for digit i (display 0 = 0x3F … display 7 = 0x07), `start` pulsed at edge k → `done` in cycle k+9 with `result`=0x7654_3210, `error`=0.
- Display 7 = 0x40, displays 6..1 = 0x00, display 0 = 0x06 with dp set (0x86) → `result`=0xAFFF_FFF1, `error`=0.
- Display 3 = 0x55, all others 0x3F → `result`=0x0000_E000, `error`=1. A following scan of all 0x3F gives `error`=0.
- Scan in progress: change `segments` at k+3 and pulse `start` at k+4 → a single `done` at k+9 carrying the k-snapshot. `reset` asserted at k+5 on a repeat run → no `done`, `result`=0.
- With `SEG_DECODER_AUTO_EN`: change display 0 from 0x3F to 0x06 while IDLE with `start`=0 → `done` 9 cycles later with nibble 0 = 1. A stable image produces no further scans.
